// File: rtl/flash_pkg.sv
// Shared constants and state types for the NOR flash program/erase controller.
// Intel-style command set, 16-bit bus mode.
package flash_pkg;

    localparam logic [15:0] CMD_PROGRAM    = 16'h0040;
    localparam logic [15:0] CMD_ERASE      = 16'h0020;
    localparam logic [15:0] CMD_CONFIRM    = 16'h00D0;
    localparam logic [15:0] CMD_CLR_SR     = 16'h0050;
    localparam logic [15:0] CMD_READ_ARRAY = 16'h00FF;

    localparam int SR_READY     = 7;
    localparam int SR_ERASE_ERR = 5;
    localparam int SR_PROG_ERR  = 4;
    localparam int SR_VPP_ERR   = 3;
    localparam int SR_LOCK_ERR  = 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD1,
        ST_CMD2,
        ST_POLL,
        ST_CLR,
        ST_RDARR,
        ST_DONE
    } state_e;

    typedef enum logic [1:0] {
        WC_IDLE,
        WC_SETUP,
        WC_LOW,
        WC_HOLD
    } wc_phase_e;

    // Error bits only mean something once the device reports ready.
    function automatic logic sr_error(input logic [7:0] sr);
        return sr[SR_READY] & (sr[SR_ERASE_ERR] | sr[SR_PROG_ERR] |
                               sr[SR_VPP_ERR]   | sr[SR_LOCK_ERR]);
    endfunction

endpackage

// File: rtl/flash_program_control_if.sv
// Request/response bundle between the flash loader (master) and the
// program/erase controller (slave).
interface flash_program_control_if;

    logic        prog_req;
    logic        erase_req;
    logic [22:0] req_addr;
    logic [15:0] req_data;
    logic        busy;
    logic        done;
    logic        error;
    logic [7:0]  status;

    modport master (
        output prog_req, erase_req, req_addr, req_data,
        input  busy, done, error, status
    );

    modport slave (
        input  prog_req, erase_req, req_addr, req_data,
        output busy, done, error, status
    );

endinterface

// File: rtl/flash_write_cycle.sv
// One flash bus write: setup clock, WE_CYCLES clocks of WE# low, hold clock.
// A start arriving during the hold clock chains straight into the next setup.
module flash_write_cycle
    import flash_pkg::*;
#(
    parameter int WE_CYCLES = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [22:0] addr_i,
    input  logic [15:0] data_i,
    output logic [22:0] flash_a_o,
    output logic [15:0] dout_o,
    output logic        drive_o,
    output logic        ce_n_o,
    output logic        we_n_o,
    output logic        cycle_done_o
);

    localparam int              CW   = (WE_CYCLES > 1) ? $clog2(WE_CYCLES) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WE_CYCLES - 1);

    wc_phase_e     ph_q, ph_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [22:0]   a_q, a_d;
    logic [15:0]   d_q, d_d;
    logic          drive_q, ce_n_q, we_n_q;

    always_comb begin
        ph_d  = ph_q;
        cnt_d = cnt_q;
        a_d   = a_q;
        d_d   = d_q;
        unique case (ph_q)
            WC_IDLE:  if (start_i) ph_d = WC_SETUP;
            WC_SETUP: begin
                ph_d  = WC_LOW;
                cnt_d = '0;
            end
            WC_LOW: begin
                if (cnt_q == LAST) ph_d = WC_HOLD;
                else               cnt_d = cnt_q + CW'(1);
            end
            WC_HOLD:  ph_d = start_i ? WC_SETUP : WC_IDLE;
            default:  ph_d = WC_IDLE;
        endcase
        if ((ph_d == WC_SETUP) && (ph_q != WC_SETUP)) begin
            a_d = addr_i;
            d_d = data_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ph_q    <= WC_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            drive_q <= 1'b0;
            ce_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
        end else begin
            ph_q    <= ph_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            drive_q <= (ph_d != WC_IDLE);
            ce_n_q  <= (ph_d == WC_IDLE);
            we_n_q  <= (ph_d != WC_LOW);
        end
    end

    // Data is only visible while drive_q is set, so it needs no reset.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    // Flags the last WE#-low clock: the sequencer advances while the hold
    // clock is on the pins, so the next setup follows without a gap.
    assign cycle_done_o = (ph_q == WC_LOW) && (cnt_q == LAST);
    assign flash_a_o    = a_q;
    assign dout_o       = d_q;
    assign drive_o      = drive_q;
    assign ce_n_o       = ce_n_q;
    assign we_n_o       = we_n_q;

endmodule

// File: rtl/flash_program_control.sv
// Word-program / block-erase sequencer for parallel NOR flash: issues the
// command writes, polls the status register, clears errors, restores read-array.
module flash_program_control
    import flash_pkg::*;
#(
    parameter int WE_CYCLES     = 3,
    parameter int OE_CYCLES     = 2,
    parameter int TIMEOUT_POLLS = 1 << 20
) (
    input  logic                          clk,
    input  logic                          rst,
    flash_program_control_if.slave        req_if,
    output logic [22:0]                   flash_a,
    inout  wire  [15:0]                   flash_d,
    output logic                          flash_rp_n,
    output logic                          flash_vpen,
    output logic                          flash_byte_n,
    output logic                          flash_ce_n,
    output logic                          flash_oe_n,
    output logic                          flash_we_n
);

    localparam int              PW        = $clog2(OE_CYCLES + 1);
    localparam int              CNTW      = $clog2(TIMEOUT_POLLS + 1);
    localparam logic [PW-1:0]   OE_LAST   = PW'(OE_CYCLES);
    localparam logic [CNTW-1:0] POLL_LAST = CNTW'(TIMEOUT_POLLS - 1);

    state_e          state_q, state_d;
    logic [PW-1:0]   ph_q, ph_d;
    logic [CNTW-1:0] pcnt_q, pcnt_d;
    logic            fresh_q;
    logic            erase_q, erase_d;
    logic [22:0]     addr_q, addr_d;
    logic [15:0]     data_q, data_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [7:0]      status_q, status_d;
    logic            rd_n_q, rd_n_d;

    logic            wc_start;
    logic [15:0]     wc_data;
    logic [22:0]     wc_a;
    logic [15:0]     wc_dout;
    logic            wc_drive, wc_ce_n, wc_we_n, wc_done;
    logic [7:0]      sr;

    assign sr = flash_d[7:0];

    // Launch the writer on the first clock of each write state so the pins
    // trail the state register by one clock.
    assign wc_start = fresh_q &&
                      ((state_q == ST_CMD1) || (state_q == ST_CMD2) ||
                       (state_q == ST_CLR)  || (state_q == ST_RDARR));

    always_comb begin
        wc_data = CMD_READ_ARRAY;
        unique case (state_q)
            ST_CMD1:  wc_data = erase_q ? CMD_ERASE : CMD_PROGRAM;
            ST_CMD2:  wc_data = erase_q ? CMD_CONFIRM : data_q;
            ST_CLR:   wc_data = CMD_CLR_SR;
            default:  wc_data = CMD_READ_ARRAY;
        endcase
    end

    flash_write_cycle #(
        .WE_CYCLES (WE_CYCLES)
    ) u_write_cycle (
        .clk          (clk),
        .rst          (rst),
        .start_i      (wc_start),
        .addr_i       (addr_q),
        .data_i       (wc_data),
        .flash_a_o    (wc_a),
        .dout_o       (wc_dout),
        .drive_o      (wc_drive),
        .ce_n_o       (wc_ce_n),
        .we_n_o       (wc_we_n),
        .cycle_done_o (wc_done)
    );

    always_comb begin
        state_d  = state_q;
        ph_d     = ph_q;
        pcnt_d   = pcnt_q;
        erase_d  = erase_q;
        addr_d   = addr_q;
        data_d   = data_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        error_d  = error_q;
        status_d = status_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_if.erase_req || req_if.prog_req) begin
                    state_d = ST_CMD1;
                    erase_d = req_if.erase_req;
                    addr_d  = req_if.req_addr;
                    data_d  = req_if.req_data;
                    busy_d  = 1'b1;
                    error_d = 1'b0;
                end
            end
            ST_CMD1: if (wc_done) state_d = ST_CMD2;
            ST_CMD2: begin
                if (wc_done) begin
                    state_d = ST_POLL;
                    ph_d    = '0;
                    pcnt_d  = '0;
                end
            end
            ST_POLL: begin
                if (ph_q == OE_LAST) begin
                    ph_d     = '0;
                    status_d = sr;
                    if (!sr[SR_READY]) begin
                        // A timeout leaves nothing to clear in SR; go straight back to read-array.
                        if (pcnt_q < POLL_LAST) begin
                            pcnt_d = pcnt_q + CNTW'(1);
                        end else begin
                            error_d = 1'b1;
                            state_d = ST_RDARR;
                        end
                    end else if (sr_error(sr)) begin
                        error_d = 1'b1;
                        state_d = ST_CLR;
                    end else begin
                        state_d = ST_RDARR;
                    end
                end else begin
                    ph_d = ph_q + PW'(1);
                end
            end
            ST_CLR:   if (wc_done) state_d = ST_RDARR;
            ST_RDARR: if (wc_done) state_d = ST_DONE;
            ST_DONE: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                busy_d  = 1'b0;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // OE#/CE# low for the first OE_CYCLES clocks of a poll slot, then one
    // recovery clock before any writer may drive the bus again.
    assign rd_n_d = !((state_q == ST_POLL) && (ph_q < OE_LAST));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            ph_q     <= '0;
            pcnt_q   <= '0;
            fresh_q  <= 1'b0;
            erase_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            status_q <= 8'h00;
            rd_n_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            pcnt_q   <= pcnt_d;
            fresh_q  <= (state_d != state_q);
            erase_q  <= erase_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            status_q <= status_d;
            rd_n_q   <= rd_n_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
    end

    assign flash_a      = wc_a;
    assign flash_d      = wc_drive ? wc_dout : 16'bz;
    assign flash_ce_n   = wc_ce_n & rd_n_q;
    assign flash_oe_n   = rd_n_q;
    assign flash_we_n   = wc_we_n;
    assign flash_rp_n   = 1'b1;
    assign flash_vpen   = 1'b1;
    assign flash_byte_n = 1'b1;

    assign req_if.busy   = busy_q;
    assign req_if.done   = done_q;
    assign req_if.error  = error_q;
    assign req_if.status = status_q;

endmodule

// File: tb/tb_flash_program_control.sv
// Directed bench for flash_program_control with a small NOR flash model that
// logs bus writes and answers status reads from a configurable SR sequence.
module tb_flash_program_control;

    logic clk = 1'b0;
    logic rst = 1'b1;

    flash_program_control_if req_if();

    logic [22:0] flash_a;
    tri1  [15:0] flash_d;
    logic        flash_rp_n, flash_vpen, flash_byte_n;
    logic        flash_ce_n, flash_oe_n, flash_we_n;

    int checks   = 0;
    int failures = 0;

    int          rd_total   = 0;
    int          rd_base    = 0;
    int          wbase      = 0;
    int          mon_viol   = 0;
    int          busy_polls = 0;
    logic [7:0]  busy_sr    = 8'h00;
    logic [7:0]  ready_sr   = 8'h80;
    logic [38:0] wlog [$];
    logic [7:0]  model_sr;

    always #5 clk = ~clk;

    flash_program_control #(
        .WE_CYCLES     (3),
        .OE_CYCLES     (2),
        .TIMEOUT_POLLS (8)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_if       (req_if),
        .flash_a      (flash_a),
        .flash_d      (flash_d),
        .flash_rp_n   (flash_rp_n),
        .flash_vpen   (flash_vpen),
        .flash_byte_n (flash_byte_n),
        .flash_ce_n   (flash_ce_n),
        .flash_oe_n   (flash_oe_n),
        .flash_we_n   (flash_we_n)
    );

    // Flash model: busy for busy_polls reads of this operation, then ready_sr.
    assign model_sr = ((rd_total - rd_base) < busy_polls) ? busy_sr : ready_sr;
    assign flash_d  = (!flash_oe_n && !flash_ce_n) ? {8'h00, model_sr} : 16'bz;

    always @(posedge flash_we_n) if (!rst) wlog.push_back({flash_a, flash_d});
    always @(posedge flash_oe_n) if (!rst) rd_total <= rd_total + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (!flash_oe_n && !flash_we_n) mon_viol <= mon_viol + 1;
            if (!flash_oe_n && (flash_d !== {8'h00, model_sr})) mon_viol <= mon_viol + 1;
            if (!flash_oe_n && flash_ce_n) mon_viol <= mon_viol + 1;
        end
    end

    task automatic do_op(input logic p, input logic e, input logic [22:0] a,
                         input logic [15:0] d, input int pulse_at,
                         output int lat, output logic err, output logic [7:0] st,
                         output logic bsy, output logic [1:0] acc);
        wbase   = wlog.size();
        rd_base = rd_total;
        @(negedge clk);
        req_if.prog_req  = p;
        req_if.erase_req = e;
        req_if.req_addr  = a;
        req_if.req_data  = d;
        @(posedge clk);
        #1 acc = {req_if.busy, req_if.error};
        @(negedge clk);
        req_if.prog_req  = 1'b0;
        req_if.erase_req = 1'b0;
        lat = -1; err = 1'b0; st = 8'h00; bsy = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(posedge clk);
            #1;
            if (req_if.done) begin
                lat = n; err = req_if.error; st = req_if.status; bsy = req_if.busy;
                break;
            end
            req_if.prog_req = (n == pulse_at);
        end
        req_if.prog_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_if.prog_req = 1'b0; req_if.erase_req = 1'b0;
        req_if.req_addr = '0;   req_if.req_data = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_vpen, flash_byte_n} !== 6'b111111) begin
            failures++; $display("FAIL reset_pins: got %b want 111111", {flash_ce_n, flash_oe_n, flash_we_n, flash_rp_n, flash_vpen, flash_byte_n});
        end
        checks++; if ({req_if.busy, req_if.done, req_if.error} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: got %b want 000", {req_if.busy, req_if.done, req_if.error});
        end
        checks++; if (req_if.status !== 8'h00) begin
            failures++; $display("FAIL reset_status: got %h want 00", req_if.status);
        end
        checks++; if (flash_a !== 23'h0) begin
            failures++; $display("FAIL reset_addr: got %h want 000000", flash_a);
        end
        checks++; if (flash_d !== 16'hFFFF) begin
            failures++; $display("FAIL reset_data_released: got %h want ffff (pulled up)", flash_d);
        end
        @(negedge clk); rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if ({req_if.busy, flash_ce_n} !== 2'b01) begin
            failures++; $display("FAIL idle_after_reset: got %b want 01", {req_if.busy, flash_ce_n});
        end
    endtask

    task automatic test_program();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        logic [38:0] exp_w [3];
        exp_w[0] = {23'h000123, 16'h0040};
        exp_w[1] = {23'h000123, 16'hBEEF};
        exp_w[2] = {23'h000123, 16'h00FF};
        busy_polls = 0; ready_sr = 8'h80;
        do_op(1'b1, 1'b0, 23'h000123, 16'hBEEF, -1, lat, err, st, bsy, acc);
        checks++; if (acc !== 2'b10) begin failures++; $display("FAIL prog_accept: got %b want 10", acc); end
        checks++; if (lat !== 19) begin failures++; $display("FAIL prog_latency: got %0d want 19", lat); end
        checks++; if ({err, bsy} !== 2'b00) begin failures++; $display("FAIL prog_err_busy: got %b want 00", {err, bsy}); end
        checks++; if (st !== 8'h80) begin failures++; $display("FAIL prog_status: got %h want 80", st); end
        checks++; if (rd_total - rd_base !== 1) begin failures++; $display("FAIL prog_reads: got %0d want 1", rd_total - rd_base); end
        checks++; if (wlog.size() - wbase !== 3) begin failures++; $display("FAIL prog_nwrites: got %0d want 3", wlog.size() - wbase); end
        for (int i = 0; i < 3 && wbase + i < wlog.size(); i++) begin
            checks++; if (wlog[wbase+i] !== exp_w[i]) begin
                failures++; $display("FAIL prog_write%0d: got %h want %h", i, wlog[wbase+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_erase();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        logic [38:0] exp_w [3];
        exp_w[0] = {23'h020000, 16'h0020};
        exp_w[1] = {23'h020000, 16'h00D0};
        exp_w[2] = {23'h020000, 16'h00FF};
        busy_polls = 4; busy_sr = 8'h00; ready_sr = 8'h80;
        do_op(1'b0, 1'b1, 23'h020000, 16'h0000, -1, lat, err, st, bsy, acc);
        checks++; if (lat !== 31) begin failures++; $display("FAIL erase_latency: got %0d want 31", lat); end
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL erase_error: got %b want 0", err); end
        checks++; if (rd_total - rd_base !== 5) begin failures++; $display("FAIL erase_reads: got %0d want 5", rd_total - rd_base); end
        checks++; if (wlog.size() - wbase !== 3) begin failures++; $display("FAIL erase_nwrites: got %0d want 3", wlog.size() - wbase); end
        for (int i = 0; i < 3 && wbase + i < wlog.size(); i++) begin
            checks++; if (wlog[wbase+i] !== exp_w[i]) begin
                failures++; $display("FAIL erase_write%0d: got %h want %h", i, wlog[wbase+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_prog_error();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        logic [38:0] exp_w [4];
        exp_w[0] = {23'h0004A0, 16'h0040};
        exp_w[1] = {23'h0004A0, 16'h1234};
        exp_w[2] = {23'h0004A0, 16'h0050};
        exp_w[3] = {23'h0004A0, 16'h00FF};
        busy_polls = 0; ready_sr = 8'h90;
        do_op(1'b1, 1'b0, 23'h0004A0, 16'h1234, -1, lat, err, st, bsy, acc);
        checks++; if (lat !== 24) begin failures++; $display("FAIL err_latency: got %0d want 24", lat); end
        checks++; if ({err, st} !== {1'b1, 8'h90}) begin failures++; $display("FAIL err_result: got %b/%h want 1/90", err, st); end
        checks++; if (wlog.size() - wbase !== 4) begin failures++; $display("FAIL err_nwrites: got %0d want 4", wlog.size() - wbase); end
        for (int i = 0; i < 4 && wbase + i < wlog.size(); i++) begin
            checks++; if (wlog[wbase+i] !== exp_w[i]) begin
                failures++; $display("FAIL err_write%0d: got %h want %h", i, wlog[wbase+i], exp_w[i]);
            end
        end
        repeat (4) @(posedge clk);
        #1;
        checks++; if ({req_if.error, req_if.done, req_if.status} !== {2'b10, 8'h90}) begin
            failures++; $display("FAIL err_held: got %b%b/%h want 10/90", req_if.error, req_if.done, req_if.status);
        end
    endtask

    task automatic test_timeout();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        busy_polls = 1000; busy_sr = 8'h00; ready_sr = 8'h80;
        do_op(1'b1, 1'b0, 23'h000777, 16'h5A5A, -1, lat, err, st, bsy, acc);
        checks++; if (acc !== 2'b10) begin failures++; $display("FAIL tmo_accept_clears_error: got %b want 10", acc); end
        checks++; if (lat !== 40) begin failures++; $display("FAIL tmo_latency: got %0d want 40", lat); end
        checks++; if (rd_total - rd_base !== 8) begin failures++; $display("FAIL tmo_reads: got %0d want 8", rd_total - rd_base); end
        checks++; if ({err, st} !== {1'b1, 8'h00}) begin failures++; $display("FAIL tmo_result: got %b/%h want 1/00", err, st); end
        checks++; if (wlog.size() - wbase !== 3) begin failures++; $display("FAIL tmo_nwrites: got %0d want 3", wlog.size() - wbase); end
        else begin
            checks++; if (wlog[wbase+2] !== {23'h000777, 16'h00FF}) begin
                failures++; $display("FAIL tmo_last_write: got %h want %h", wlog[wbase+2], {23'h000777, 16'h00FF});
            end
        end
        busy_polls = 0;
    endtask

    task automatic test_reset_mid();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        bit found = 1'b0;
        busy_polls = 0; ready_sr = 8'h80;
        @(negedge clk);
        req_if.prog_req = 1'b1; req_if.req_addr = 23'h000055; req_if.req_data = 16'hAAAA;
        @(posedge clk);
        @(negedge clk);
        req_if.prog_req = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (!flash_we_n) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin failures++; $display("FAIL mid_we_low_seen: got 0 want 1"); end
        rst = 1'b1;
        #1;
        checks++; if ({flash_we_n, flash_ce_n, req_if.busy} !== 3'b110) begin
            failures++; $display("FAIL mid_async_reset: got %b want 110", {flash_we_n, flash_ce_n, req_if.busy});
        end
        checks++; if (flash_d !== 16'hFFFF) begin
            failures++; $display("FAIL mid_data_released: got %h want ffff (pulled up)", flash_d);
        end
        @(negedge clk); rst = 1'b0;
        do_op(1'b1, 1'b0, 23'h000123, 16'hBEEF, -1, lat, err, st, bsy, acc);
        checks++; if ({lat, err} !== {32'd19, 1'b0}) begin
            failures++; $display("FAIL mid_recovery: got lat %0d err %b want lat 19 err 0", lat, err);
        end
    endtask

    task automatic test_both_and_ignore();
        int lat; logic err, bsy; logic [7:0] st; logic [1:0] acc;
        bit saw_busy = 1'b0;
        logic [38:0] exp_w [3];
        exp_w[0] = {23'h012345, 16'h0020};
        exp_w[1] = {23'h012345, 16'h00D0};
        exp_w[2] = {23'h012345, 16'h00FF};
        busy_polls = 0; ready_sr = 8'h80;
        do_op(1'b1, 1'b1, 23'h012345, 16'h9999, 5, lat, err, st, bsy, acc);
        for (int n = 0; n < 30; n++) begin
            @(posedge clk);
            #1;
            if (req_if.busy) saw_busy = 1'b1;
        end
        checks++; if (lat !== 19) begin failures++; $display("FAIL both_latency: got %0d want 19", lat); end
        checks++; if (saw_busy !== 1'b0) begin failures++; $display("FAIL busy_req_ignored: got busy %b want 0", saw_busy); end
        checks++; if (wlog.size() - wbase !== 3) begin failures++; $display("FAIL both_nwrites: got %0d want 3", wlog.size() - wbase); end
        for (int i = 0; i < 3 && wbase + i < wlog.size(); i++) begin
            checks++; if (wlog[wbase+i] !== exp_w[i]) begin
                failures++; $display("FAIL both_write%0d: got %h want %h", i, wlog[wbase+i], exp_w[i]);
            end
        end
    endtask

    task automatic test_bus_monitor();
        checks++; if (mon_viol !== 0) begin
            failures++; $display("FAIL bus_contention: got %0d violations want 0", mon_viol);
        end
    endtask

    initial begin
        test_reset();
        test_program();
        test_erase();
        test_prog_error();
        test_timeout();
        test_reset_mid();
        test_both_and_ignore();
        test_bus_monitor();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/flash_program_control.md
# flash_program_control

Write-side companion to the flash read controller: executes word-program and block-erase command sequences on the parallel NOR flash (Intel-style command set, 16-bit mode). It then polls the status register until ready and returns the flash to read-array mode. It sits between the flash loader / system bus and the flash pins. Bus arbitration with the read path is external: only one controller drives the pins at a time.

## Interface
- WE_CYCLES, 3: cycles WE# is held low per bus write (≥1)
- OE_CYCLES, 2: cycles OE# is held low per status read; SR is sampled on the last cycle (≥1)
- TIMEOUT_POLLS, 2^20: maximum status reads before giving up
- clk  in  1  system clock
- rst  in  1  reset; one clock domain; reset is asynchronous and active-high
- prog_req  in  1  start a word program; sampled only in IDLE
- erase_req  in  1  start a block erase; sampled only in IDLE; wins over prog_req
- req_addr  in  23  word address, or any address inside the block for erase
- req_data  in  16  program data
- busy  out  1  high from the acceptance cycle until done
- done  out  1  one-cycle pulse at the end of every accepted operation
- error  out  1  valid with done: status error or timeout
- status  out  8  last status-register value read; held until the next acceptance
- flash_a  out  23
- flash_d  inout  16
- flash_rp_n, flash_vpen, flash_byte_n  out  1 each: constant 1
- flash_ce_n, flash_oe_n, flash_we_n  out  1 each: active low

## Operation
- Reset values:
  - flash_a=0, flash_d=Z
  - ce_n=oe_n=we_n=1
  - rp_n=vpen=byte_n=1
  - busy=done=error=0, status=0
  - state IDLE
- Acceptance (IDLE):
  - Latch req_addr and req_data, clear error, set busy.
  - If both requests are high, perform an erase.
  - Requests while busy are ignored and are not queued.
- States:
  - IDLE → CMD1 → CMD2 → POLL → (CLR if error) → RDARR → DONE → IDLE
- Bus writes (all at the latched address):
  - CMD1 writes 0x0040 for program, 0x0020 for erase.
  - CMD2 writes req_data for program, 0x00D0 for erase.
  - CLR writes 0x0050.
  - RDARR writes 0x00FF.
- POLL:
  - One read per iteration.
  - SR = flash_d[7:0] is copied into status.
  - If SR[7]=0 and the poll count < TIMEOUT_POLLS, repeat.
  - Error when SR[7]=1 and any of SR[5], SR[4], SR[3], SR[1] is set, or on timeout. A timeout also sets error, and status holds the last SR read.
  - No error → RDARR.
  - Error → CLR → RDARR.
- DONE: done=1 for one cycle and busy falls in the same cycle. error stays valid until the next acceptance.
- flash_d is driven only during write-cycle phases and is Z otherwise.
- Reset mid-operation: all outputs return to reset values immediately. The flash may be left mid-operation; recovery is the caller's job.

## Timing
- Bus write cycle, WE_CYCLES+2 clocks:
  - 1 setup clock: ce_n=0, address and data driven, we_n=1.
  - WE_CYCLES clocks with we_n=0.
  - 1 hold clock: we_n=1, data still driven.
  - ce_n returns to 1 afterwards.
- Status read, OE_CYCLES+1 clocks:
  - ce_n=oe_n=0, flash_d Z.
  - Sample on the last low clock.
  - 1 recovery clock with oe_n=ce_n=1.
- Contention rules:
  - oe_n=0 and a driven flash_d never overlap.
  - we_n and oe_n are never both 0.
- Latency with defaults, ready on the first poll, no error:
  - acceptance + 5 (CMD1) + 5 (CMD2) + 3 (POLL) + 5 (RDARR).
  - done is asserted 19 cycles after the acceptance edge.
  - Each extra poll adds 3 cycles; CLR adds 5.
- All outputs are registered; pin changes appear one clock after the state change.

## Structure
- Package flash_pkg holds:
  - command constants: CMD_PROGRAM 0x40, CMD_ERASE 0x20, CMD_CONFIRM 0xD0, CMD_CLR_SR 0x50, CMD_READ_ARRAY 0xFF
  - SR bit indices: READY 7, ERASE_ERR 5, PROG_ERR 4, VPP_ERR 3, LOCK_ERR 1
  - the state enum
- Sub-module flash_write_cycle:
  - Owns one WE# pulse: setup / low / hold counter.
  - Inputs: start, addr, data. Outputs: the pins it drives, plus cycle_done.
  - The top FSM sequences it and the poll reads.

## Test plan
- Program addr 0x000123, data 0xBEEF; model ready on the 1st poll with SR=0x80 → writes (0x000123,0x0040) then (0x000123,0xBEEF), one read, write 0x00FF; done at +19; error=0; status=0x80.
- Erase addr 0x020000; model busy for 4 polls then SR=0x80 → writes 0x0020, 0x00D0, 5 reads, 0x00FF; done at +31; error=0.
- Program with model SR=0x90 → error=1, status=0x90; writes 0x0050 then 0x00FF; done at +24.
- TIMEOUT_POLLS=8, model never ready → exactly 8 reads, error=1, status=0x00, then 0x00FF, done.
- rst asserted while we_n=0 → we_n, ce_n high and flash_d Z in the same cycle (asynchronous), busy=0; a subsequent program completes normally.
- prog_req and erase_req high together in IDLE → erase sequence; prog_req pulsed while busy → ignored. Bus monitor checks throughout: no oe_n=0 while flash_d is driven.
